// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and TX buffer sequencer states.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      TXF_IDLE,
      TXF_LAUNCH,
      TXF_WAIT_DONE
   } tx_fifo_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a separately held occupancy count and a synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;

   assign full    = (count == (ADDR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   assign pop  = rd_en && !empty;
   assign push = wr_en && !flush && (!full || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Flush wins over pointer/count updates; a pop in the flush cycle still delivers rd_data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (ADDR_W+1)'(1);
            2'b01:   count <= count - (ADDR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the UART transmitter: launches one byte at a time
// with a tx_start pulse and waits for tx_done before launching the next.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              tx_busy,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_done
);

   tx_fifo_state_e    state;
   tx_fifo_state_e    state_next;
   logic              pop;
   logic [DATA_W-1:0] head;

   uart_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (head),
      .flush   (flush),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign tx_busy = (state != TXF_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= TXF_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         TXF_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = TXF_LAUNCH;
            end
         end
         TXF_LAUNCH:    state_next = TXF_WAIT_DONE;
         TXF_WAIT_DONE: if (tx_done) state_next = TXF_IDLE;
         default:       state_next = TXF_IDLE;
      endcase
   end

   // tx_start follows the pop by one cycle, so it is high exactly during LAUNCH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_start <= 1'b0;
         tx_data  <= '0;
         overflow <= 1'b0;
      end else begin
         tx_start <= pop;
         if (pop) begin
            tx_data <= head;
         end
         overflow <= wr_en && !flush && full && !pop;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       flush;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: a byte queue plus the byte currently owned by the transmitter.
   logic [7:0] q[$];
   bit         m_in_flight;
   bit         m_launching;
   bit         m_start;
   bit         m_ovf;
   logic [7:0] m_data;

   uart_tx_fifo #(
      .DATA_W (8),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .flush    (flush),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_done  (tx_done)
   );

   always #4 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_in_flight = 0;
      m_launching = 0;
      m_start     = 0;
      m_ovf       = 0;
      m_data      = '0;
   endtask

   task automatic model_step(input bit w, input logic [7:0] d, input bit f, input bit dn);
      int sz;
      bit pop;
      sz  = q.size();
      pop = !m_in_flight && (sz > 0);
      m_ovf   = 0;
      m_start = pop;
      if (pop) begin
         m_data      = q.pop_front();
         m_in_flight = 1;
         m_launching = 1;
      end else if (m_launching) begin
         m_launching = 0;
      end else if (m_in_flight && dn) begin
         m_in_flight = 0;
      end
      if (f) begin
         q.delete();
      end else if (w) begin
         if (sz < DEPTH || pop) q.push_back(d);
         else m_ovf = 1;
      end
   endtask

   task automatic check_all();
      chk("count",    32'(count),    32'(q.size()));
      chk("full",     32'(full),     32'(q.size() == DEPTH));
      chk("empty",    32'(empty),    32'(q.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("tx_busy",  32'(tx_busy),  32'(m_in_flight));
      chk("tx_start", 32'(tx_start), 32'(m_start));
      chk("tx_data",  32'(tx_data),  32'(m_data));
   endtask

   // Called at a negedge: drive inputs, advance the model, check after the next edge.
   task automatic cycle(input bit w, input logic [7:0] d, input bit f, input bit dn);
      wr_en   = w;
      wr_data = d;
      flush   = f;
      tx_done = dn;
      model_step(w, d, f, dn);
      @(negedge clk);
      check_all();
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && (q.size() != 0 || m_in_flight); i++) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b1);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk("drain_idle", 32'({tx_busy, empty}), 32'b01);
   endtask

   initial begin
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      flush   = 1'b0;
      tx_done = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b1;

      // Single byte: tx_start two cycles after the push.
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("t1_no_early_start", 32'(tx_start), 32'd0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t1_start", 32'(tx_start), 32'd1);
      chk("t1_data", 32'(tx_data), 32'hA5);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1 * (i == 3));
      drain();

      // Stalled transmitter: fill to full, then one dropped push.
      for (int i = 1; i <= 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk("t2_full", 32'(full), 32'd1);
      cycle(1'b1, 8'h12, 1'b0, 1'b0);
      chk("t2_overflow", 32'(overflow), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t2_overflow_pulse", 32'(overflow), 32'd0);

      // Full FIFO, push lands in the pop cycle.
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
      chk("t3_no_overflow", 32'(overflow), 32'd0);
      chk("t3_count", 32'(count), 32'd16);
      drain();

      // Randomized traffic: wrap-around, flushes, tx_done in every state.
      for (int i = 0; i < 500; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) == 0));
      end
      drain();

      // Flush while the first byte is in WAIT_DONE.
      cycle(1'b1, 8'h10, 1'b0, 1'b0);
      cycle(1'b1, 8'h20, 1'b0, 1'b0);
      cycle(1'b1, 8'h30, 1'b0, 1'b0);
      for (int i = 0; i < 10 && !(m_in_flight && !m_launching); i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_data", 32'(tx_data), 32'h10);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset with 5 queued and one byte in flight.
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t6_pre_count", 32'(count), 32'd5);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t6_restart", 32'(tx_start), 32'd1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
